mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, giving the number of cycles inserted between request capture and array access (legal 0..3).
REQ-002 SHALL have parameter PROTECT_LIMIT, default 8'd16: first address that is not write-protected (used only under REQ-030).
REQ-003 SHALL use one clock; reset is synchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 MAR  input  8  request word address.
REQ-006 MBR_out  input  24  write data from the initiator.
REQ-007 MBR_in  output  24  read data to the initiator.
REQ-008 Mem_EN  input  1  request valid; held high until Mem_RDY is seen.
REQ-009 Mem_CS  input  1  operation: 0 = read, 1 = write.
REQ-010 Mem_RDY  output  1  one-cycle pulse; access complete.
REQ-011 Mem_ERR  output  1  one-cycle pulse coincident with Mem_RDY; write rejected.

Function
REQ-012 SHALL hold a 256 x 24-bit word array; each address selects one word.
REQ-013 SHALL implement the states IDLE, WAIT, ACCESS and DONE.
REQ-014 IDLE: when Mem_EN=1, capture MAR, Mem_CS and MBR_out; go to WAIT if WAIT_STATES>0, else go to ACCESS.
REQ-015 WAIT: load the counter with WAIT_STATES-1 on entry, decrement each cycle, and go to ACCESS when it reaches 0.
REQ-016 ACCESS: a read registers array[addr] onto MBR_in; a write commits the captured data to array[addr]; Mem_RDY=1 for exactly this cycle; then go to DONE.
REQ-017 Request-to-Mem_RDY latency SHALL be WAIT_STATES+1 cycles, counted from the IDLE capture edge.
REQ-018 DONE: stay while Mem_EN=1; go to IDLE on Mem_EN=0. No new request is captured in DONE.
REQ-019 Changes to MAR, Mem_CS or MBR_out after capture SHALL be ignored until the next IDLE capture.
REQ-020 If Mem_EN drops during WAIT: abort and go to IDLE; no write is committed, no Mem_RDY, MBR_in unchanged.
REQ-021 MBR_in SHALL hold the last read data until the next completed read; writes do not alter it.
REQ-022 A read after a write to the same address SHALL return the newly written data.
REQ-023 Addresses 0..255 are all valid; there is no wrap or out-of-range case.

Reset
REQ-024 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, counter=0, MBR_in=0, Mem_RDY=0 and Mem_ERR=0.
REQ-025 Reset SHALL NOT clear the array contents.
REQ-026 Reset during WAIT SHALL abort the access without committing the write.
REQ-027 An access is accepted at the earliest on the first edge with rst_n=1 and Mem_EN=1.

Configuration
REQ-028 Macro MEM_WRITE_PROTECT_EN SHALL select write protection.
REQ-029 Without the macro: every write commits, and Mem_ERR is tied to 0.
REQ-030 With the macro: a write to addr < PROTECT_LIMIT is dropped in ACCESS, and Mem_ERR pulses together with Mem_RDY; reads are unaffected.

Structure
REQ-031 Package mem_pkg SHALL hold ADDR_W=8, DATA_W=24, MEM_READ=0, MEM_WRITE=1 and the state encoding.
REQ-032 Sub-module mem_array SHALL contain the synchronous single-port 256x24 array (one write port, registered read); the FSM, capture registers and counter stay in mem_responder.

Verification
REQ-033 WAIT_STATES=1: write MAR=8'd40, MBR_out=24'h00ABCD, then read MAR=40 -> Mem_RDY 2 cycles after each capture; read returns MBR_in=24'h00ABCD.
REQ-034 WAIT_STATES=0: read MAR=8'd255 after writing 24'hFFFFFF -> Mem_RDY 1 cycle after capture, MBR_in=24'hFFFFFF.
REQ-035 WAIT_STATES=3: write addr 50, value 24'h000123; drop Mem_EN in the 2nd WAIT cycle; then read addr 50 -> no Mem_RDY for the aborted access; the read returns the prior contents.
REQ-036 Hold Mem_EN high for 4 cycles after Mem_RDY -> exactly one Mem_RDY pulse; no second access until Mem_EN=0 then 1.
REQ-037 MEM_WRITE_PROTECT_EN defined: write 24'h000777 to addr 5 -> Mem_RDY and Mem_ERR both pulse; a read of addr 5 returns the old value. A write to addr 16 commits with Mem_ERR=0.
REQ-038 Pulse rst_n low during ACCESS of a read -> the next edge gives MBR_in=0, Mem_RDY=0, state IDLE; array data is intact on a later read.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, opcodes, FSM encoding and request record for the memory responder.
package mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 2;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              op;
        logic [DATA_W-1:0] data;
    } req_t;
endpackage

// File: rtl/mem_array.sv
// 256x24 single-port word array with a registered read port.
// The array itself is never reset; only the read register clears.
module mem_array
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[addr];
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder: IDLE/WAIT/ACCESS/DONE FSM in front of mem_array.
// Define MEM_WRITE_PROTECT_EN to reject writes below PROTECT_LIMIT with Mem_ERR.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                WAIT_STATES   = 1,
    parameter logic [ADDR_W-1:0] PROTECT_LIMIT = 8'd16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] MAR,
    input  logic [DATA_W-1:0] MBR_out,
    output logic [DATA_W-1:0] MBR_in,
    input  logic              Mem_EN,
    input  logic              Mem_CS,
    output logic              Mem_RDY,
    output logic              Mem_ERR
);
`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d, cur;
    logic              rdy_q, rdy_d, err_q, err_d;
    logic              go, hit, we, re;

    // The array operation fires on the edge that enters ACCESS, so read data
    // and Mem_RDY appear together during the ACCESS cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        cur     = req_q;
        go      = 1'b0;
        case (state_q)
            IDLE: begin
                if (Mem_EN) begin
                    req_d = '{addr: MAR, op: Mem_CS, data: MBR_out};
                    cur   = req_d;
                    if (WAIT_STATES == 0) begin
                        state_d = ACCESS;
                        go      = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!Mem_EN) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACCESS;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACCESS:  state_d = DONE;
            DONE:    if (!Mem_EN) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!rst_n) go = 1'b0;
        hit   = (cur.addr < PROTECT_LIMIT);
        we    = go && (cur.op == MEM_WRITE) && !(PROT_EN && hit);
        re    = go && (cur.op == MEM_READ);
        rdy_d = go;
        err_d = go && PROT_EN && (cur.op == MEM_WRITE) && hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            req_q   <= req_d;
        end
    end

    mem_array u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .re    (re),
        .addr  (cur.addr),
        .wdata (cur.data),
        .rdata (MBR_in)
    );

    assign Mem_RDY = rdy_q;
    assign Mem_ERR = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 3 wait states) against a word-array model.
module tb_mem_responder;
    localparam int NDUT = 3;
`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0][7:0]  mar     = '0;
    logic [NDUT-1:0][23:0] mbr_out = '0;
    logic [NDUT-1:0]       en      = '0;
    logic [NDUT-1:0]       cs      = '0;
    logic [NDUT-1:0][23:0] mbr_in;
    logic [NDUT-1:0]       rdy, err;

    mem_responder #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .MAR(mar[0]), .MBR_out(mbr_out[0]),
        .MBR_in(mbr_in[0]), .Mem_EN(en[0]), .Mem_CS(cs[0]), .Mem_RDY(rdy[0]), .Mem_ERR(err[0]));
    mem_responder #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst_n(rst_n), .MAR(mar[1]), .MBR_out(mbr_out[1]),
        .MBR_in(mbr_in[1]), .Mem_EN(en[1]), .Mem_CS(cs[1]), .Mem_RDY(rdy[1]), .Mem_ERR(err[1]));
    mem_responder #(.WAIT_STATES(3)) dut2 (.clk(clk), .rst_n(rst_n), .MAR(mar[2]), .MBR_out(mbr_out[2]),
        .MBR_in(mbr_in[2]), .Mem_EN(en[2]), .Mem_CS(cs[2]), .Mem_RDY(rdy[2]), .Mem_ERR(err[2]));

    logic [23:0] mem_m [NDUT][256];
    bit          known [NDUT][256];
    logic [23:0] last_rd [NDUT];
    bit          last_known [NDUT];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 1 : 3;
    endfunction

    function automatic bit blocked(input int a, input bit w);
        return PROT && w && (a < 16);
    endfunction

    task automatic after_reset_model();
        for (int k = 0; k < NDUT; k++) begin
            last_rd[k]    = 24'h0;
            last_known[k] = 1'b1;
        end
    endtask

    // One full transaction: random input churn after capture, optional abort in WAIT,
    // optional extra cycles of Mem_EN held high after completion.
    task automatic do_access(input int k, input bit w, input int a, input logic [23:0] d,
                             input int hold, input int abort_at);
        int          ws;
        bit          chk_rd, exp_err;
        logic [23:0] exp_rd;
        ws      = ws_of(k);
        chk_rd  = !w && known[k][a];
        exp_rd  = mem_m[k][a];
        exp_err = blocked(a, w);
        @(negedge clk);
        en[k] = 1'b1; cs[k] = w; mar[k] = 8'(a); mbr_out[k] = d;
        if (abort_at > 0) begin
            for (int c = 1; c <= abort_at; c++) begin
                @(negedge clk);
                mar[k] = 8'($urandom); mbr_out[k] = 24'($urandom); cs[k] = 1'($urandom);
                n_cmp++;
                if (rdy[k] !== 1'b0) begin
                    n_bad++; $display("FAIL abort_wait dut%0d c%0d: rdy=%b expected 0", k, c, rdy[k]);
                end
            end
            en[k] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                n_cmp++;
                if (rdy[k] !== 1'b0 || err[k] !== 1'b0) begin
                    n_bad++; $display("FAIL abort_rdy dut%0d: rdy=%b err=%b expected 0 0", k, rdy[k], err[k]);
                end
                if (last_known[k]) begin
                    n_cmp++;
                    if (mbr_in[k] !== last_rd[k]) begin
                        n_bad++; $display("FAIL abort_mbr dut%0d: got %h expected %h", k, mbr_in[k], last_rd[k]);
                    end
                end
            end
            return;
        end
        for (int c = 1; c <= ws + 1; c++) begin
            @(negedge clk);
            mar[k] = 8'($urandom); mbr_out[k] = 24'($urandom); cs[k] = 1'($urandom);
            n_cmp++;
            if (rdy[k] !== (c == ws + 1)) begin
                n_bad++; $display("FAIL latency dut%0d c%0d: rdy=%b expected %b", k, c, rdy[k], (c == ws + 1));
            end
        end
        n_cmp++;
        if (err[k] !== exp_err) begin
            n_bad++; $display("FAIL err dut%0d addr%0d: err=%b expected %b", k, a, err[k], exp_err);
        end
        if (w) begin
            if (last_known[k]) begin
                n_cmp++;
                if (mbr_in[k] !== last_rd[k]) begin
                    n_bad++; $display("FAIL wr_keeps_mbr dut%0d: got %h expected %h", k, mbr_in[k], last_rd[k]);
                end
            end
            if (!exp_err) begin
                mem_m[k][a] = d; known[k][a] = 1'b1;
            end
        end else begin
            if (chk_rd) begin
                n_cmp++;
                if (mbr_in[k] !== exp_rd) begin
                    n_bad++; $display("FAIL read dut%0d addr%0d: got %h expected %h", k, a, mbr_in[k], exp_rd);
                end
            end
            last_rd[k] = exp_rd; last_known[k] = chk_rd;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy[k] !== 1'b0 || err[k] !== 1'b0) begin
                n_bad++; $display("FAIL hold dut%0d h%0d: rdy=%b err=%b expected 0 0", k, h, rdy[k], err[k]);
            end
        end
        en[k] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy[k] !== 1'b0) begin
                n_bad++; $display("FAIL release dut%0d: rdy=%b expected 0", k, rdy[k]);
            end
        end
        if (last_known[k]) begin
            n_cmp++;
            if (mbr_in[k] !== last_rd[k]) begin
                n_bad++; $display("FAIL mbr_hold dut%0d: got %h expected %h", k, mbr_in[k], last_rd[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = '1; cs = '1; mar = '0; mbr_out = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                n_cmp++;
                if (rdy[k] !== 1'b0 || err[k] !== 1'b0 || mbr_in[k] !== 24'h0) begin
                    n_bad++; $display("FAIL reset dut%0d: rdy=%b err=%b mbr=%h expected 0 0 000000",
                                      k, rdy[k], err[k], mbr_in[k]);
                end
            end
        end
        en = '0;
        @(negedge clk);
        rst_n = 1'b1;
        after_reset_model();
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_access(1, 1'b1, 40, 24'h00ABCD, 0, 0);
        do_access(1, 1'b0, 40, 24'h0, 0, 0);
        do_access(0, 1'b1, 255, 24'hFFFFFF, 0, 0);
        do_access(0, 1'b0, 255, 24'h0, 1, 0);
        do_access(2, 1'b1, 50, 24'h000111, 0, 0);
        do_access(2, 1'b1, 50, 24'h000123, 0, 2);
        do_access(2, 1'b0, 50, 24'h0, 0, 0);
        do_access(1, 1'b0, 40, 24'h0, 4, 0);
        do_access(1, 1'b1, 5, 24'h000555, 0, 0);
        do_access(1, 1'b1, 5, 24'h000777, 0, 0);
        do_access(1, 1'b0, 5, 24'h0, 0, 0);
        do_access(1, 1'b1, 16, 24'h000888, 0, 0);
        do_access(1, 1'b0, 16, 24'h0, 0, 0);
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        en[1] = 1'b1; cs[1] = 1'b0; mar[1] = 8'd40;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (rdy[1] !== 1'b1 || mbr_in[1] !== mem_m[1][40]) begin
            n_bad++; $display("FAIL rst_access_pre: rdy=%b mbr=%h expected 1 %h", rdy[1], mbr_in[1], mem_m[1][40]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rdy[1] !== 1'b0 || mbr_in[1] !== 24'h0) begin
            n_bad++; $display("FAIL rst_access: rdy=%b mbr=%h expected 0 000000", rdy[1], mbr_in[1]);
        end
        rst_n = 1'b1; en[1] = 1'b0;
        after_reset_model();
        @(negedge clk);
        do_access(1, 1'b0, 40, 24'h0, 0, 0);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        en[2] = 1'b1; cs[2] = 1'b1; mar[2] = 8'd50; mbr_out[2] = 24'h0000EE;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; en[2] = 1'b0;
        after_reset_model();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (rdy[2] !== 1'b0) begin
                n_bad++; $display("FAIL rst_wait_rdy: rdy=%b expected 0", rdy[2]);
            end
        end
        do_access(2, 1'b0, 50, 24'h0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 150; i++) begin
            int k, a, ab;
            bit w;
            k  = int'($urandom_range(0, NDUT - 1));
            w  = 1'($urandom);
            a  = int'($urandom_range(0, 63));
            ab = 0;
            if (ws_of(k) > 0 && $urandom_range(0, 4) == 0) ab = int'($urandom_range(1, ws_of(k)));
            do_access(k, w, a, 24'($urandom), int'($urandom_range(0, 2)), ab);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_in_access();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
